// File: rtl/ifm_ld_pkg.sv
// Shared types and width helpers for the input-feature-map load controller.
package ifm_ld_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitBuf,
    StIssue,
    StDrain,
    StDone
  } ifm_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Bits needed to hold the values 0 .. n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold the values 0 .. n.
  function automatic int unsigned lvl_w(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/ifm_tile_addr.sv
// Burst/row/tile position counters and the AXI byte address of the current burst.
module ifm_tile_addr #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned IW        = 224,
  parameter int unsigned IH        = 224,
  parameter int unsigned TILE_W    = 32,
  parameter int unsigned TILE_H    = 7,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic          step_burst_i,
  input  logic          step_tile_i,
  output logic [AW-1:0] araddr_o,
  output logic          tile_last_burst_o,
  output logic          map_last_tile_o
);
  import ifm_ld_pkg::*;

  localparam int unsigned ROW_BURSTS = TILE_W / BURST_LEN;
  localparam int unsigned TX         = IW / TILE_W;
  localparam int unsigned TY         = IH / TILE_H;
  localparam int unsigned BPW        = DW / 8;
  localparam int unsigned BW         = cnt_w(ROW_BURSTS);
  localparam int unsigned RW         = cnt_w(TILE_H);
  localparam int unsigned XW         = cnt_w(TX);
  localparam int unsigned YW         = cnt_w(TY);

  logic [AW-1:0] base_q, base_d;
  logic [BW-1:0] b_q, b_d;
  logic [RW-1:0] r_q, r_d;
  logic [XW-1:0] tx_q, tx_d;
  logic [YW-1:0] ty_q, ty_d;
  logic          b_last, r_last, tx_last, ty_last;
  logic [AW-1:0] row, col;

  assign b_last  = (b_q == BW'(ROW_BURSTS - 1));
  assign r_last  = (r_q == RW'(TILE_H - 1));
  assign tx_last = (tx_q == XW'(TX - 1));
  assign ty_last = (ty_q == YW'(TY - 1));

  assign tile_last_burst_o = b_last & r_last;
  assign map_last_tile_o   = tx_last & ty_last;

  always_comb begin
    base_d = base_q;
    b_d    = b_q;
    r_d    = r_q;
    tx_d   = tx_q;
    ty_d   = ty_q;
    if (load_i) begin
      base_d = base_i;
      b_d    = '0;
      r_d    = '0;
      tx_d   = '0;
      ty_d   = '0;
    end else if (step_tile_i) begin
      b_d = '0;
      r_d = '0;
      if (tx_last) begin
        tx_d = '0;
        ty_d = ty_last ? '0 : ty_q + YW'(1);
      end else begin
        tx_d = tx_q + XW'(1);
      end
    end else if (step_burst_i) begin
      // Wraps to the tile origin after the last burst, so the next tile starts at b=r=0.
      if (b_last) begin
        b_d = '0;
        r_d = r_last ? '0 : r_q + RW'(1);
      end else begin
        b_d = b_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
      b_q    <= '0;
      r_q    <= '0;
      tx_q   <= '0;
      ty_q   <= '0;
    end else begin
      base_q <= base_d;
      b_q    <= b_d;
      r_q    <= r_d;
      tx_q   <= tx_d;
      ty_q   <= ty_d;
    end
  end

  assign row      = AW'(ty_q) * AW'(TILE_H) + AW'(r_q);
  assign col      = AW'(tx_q) * AW'(TILE_W) + AW'(b_q) * AW'(BURST_LEN);
  assign araddr_o = base_q + (row * AW'(IW) + col) * AW'(BPW);

endmodule

// File: rtl/ifm_load_ctrl.sv
// Issues AXI read bursts tile by tile for one input feature map, capping outstanding bursts.
// Optional IFM_LOAD_PERF_EN adds saturating stall and buffer-wait cycle counters.
module ifm_load_ctrl #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned IW        = 224,
  parameter int unsigned IH        = 224,
  parameter int unsigned TILE_W    = 32,
  parameter int unsigned TILE_H    = 7,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned MAX_OS    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic          buf_free_i,
  output logic          busy_o,
  output logic          tile_done_o,
  output logic          map_done_o,
  output logic [AW-1:0] araddr_o,
  output logic [7:0]    arlen_o,
  output logic [1:0]    arburst_o,
  output logic          arvalid_o,
  input  logic          arready_i,
  input  logic          rlast_hs_i,
`ifdef IFM_LOAD_PERF_EN
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   bufwait_cnt_o,
`endif
  output logic          err_o
);
  import ifm_ld_pkg::*;

  localparam int unsigned OSW = lvl_w(MAX_OS);

  ifm_state_e     state_q, state_d;
  logic [OSW-1:0] os_q, os_d;
  logic           arvalid_q, arvalid_d;
  logic           err_q, err_d;
  logic           load, step_tile, ar_hs, os_dec, os_room;
  logic           tile_last_burst, map_last_tile;

  assign ar_hs  = arvalid_q & arready_i;
  assign os_dec = rlast_hs_i & (os_q != '0);
  assign os_d   = os_q + OSW'(ar_hs) - OSW'(os_dec);
  // Request decision ignores this cycle's rlast credit; it is seen one cycle later.
  assign os_room = (32'(os_q) + 32'(ar_hs)) < MAX_OS;
  assign err_d   = (load ? 1'b0 : err_q) | (rlast_hs_i & (os_q == '0));

  always_comb begin
    state_d     = state_q;
    arvalid_d   = 1'b0;
    load        = 1'b0;
    step_tile   = 1'b0;
    tile_done_o = 1'b0;
    map_done_o  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = StWaitBuf;
        end
      end
      StWaitBuf: begin
        if (buf_free_i) begin
          state_d   = StIssue;
          arvalid_d = os_room;
        end
      end
      StIssue: begin
        if (ar_hs && tile_last_burst) begin
          state_d = StDrain;
        end else begin
          arvalid_d = os_room;
        end
      end
      StDrain: begin
        if (os_q == '0) begin
          tile_done_o = 1'b1;
          if (map_last_tile) begin
            state_d = StDone;
          end else begin
            step_tile = 1'b1;
            state_d   = StWaitBuf;
          end
        end
      end
      StDone: begin
        map_done_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      os_q      <= '0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_q      <= os_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
    end
  end

  ifm_tile_addr #(
    .AW        (AW),
    .DW        (DW),
    .IW        (IW),
    .IH        (IH),
    .TILE_W    (TILE_W),
    .TILE_H    (TILE_H),
    .BURST_LEN (BURST_LEN)
  ) u_tile_addr (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_i            (load),
    .base_i            (base_addr_i),
    .step_burst_i      (ar_hs),
    .step_tile_i       (step_tile),
    .araddr_o          (araddr_o),
    .tile_last_burst_o (tile_last_burst),
    .map_last_tile_o   (map_last_tile)
  );

  assign busy_o    = (state_q != StIdle);
  assign arvalid_o = arvalid_q;
  assign arlen_o   = 8'(BURST_LEN - 1);
  assign arburst_o = AXI_BURST_INCR;
  assign err_o     = err_q;

`ifdef IFM_LOAD_PERF_EN
  logic [31:0] stall_cnt_q, bufwait_cnt_q;
  logic        stall_inc, bufwait_inc;

  assign stall_inc   = (state_q == StIssue) &&
                       ((arvalid_q && !arready_i) || (os_q == OSW'(MAX_OS)));
  assign bufwait_inc = (state_q == StWaitBuf) && !buf_free_i;

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      stall_cnt_q   <= '0;
      bufwait_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bufwait_inc && (bufwait_cnt_q != '1)) bufwait_cnt_q <= bufwait_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign bufwait_cnt_o = bufwait_cnt_q;
`endif

endmodule

// File: tb/tb_ifm_load_ctrl.sv
// Directed checks of latency/outstanding cap/reset, then a randomized full-map run
// checked every cycle against an index-based address and completion model.
module tb_ifm_load_ctrl;
  localparam int unsigned AW = 32, DW = 32, IW = 224, IH = 224;
  localparam int unsigned TILE_W = 32, TILE_H = 7, BURST_LEN = 16, MAX_OS = 4;
  localparam int RB  = TILE_W / BURST_LEN;
  localparam int TB  = TILE_H * RB;
  localparam int TX  = IW / TILE_W;
  localparam int TY  = IH / TILE_H;
  localparam int NT  = TX * TY;
  localparam int BPW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n, start, buf_free, arready, rlast_hs;
  logic [AW-1:0] base_addr;
  logic          busy, tile_done, map_done, arvalid, err;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [1:0]    arburst;
`ifdef IFM_LOAD_PERF_EN
  logic [31:0]   stall_cnt, bufwait_cnt;
`endif

  always #5 clk = ~clk;

  ifm_load_ctrl #(
    .AW(AW), .DW(DW), .IW(IW), .IH(IH), .TILE_W(TILE_W), .TILE_H(TILE_H),
    .BURST_LEN(BURST_LEN), .MAX_OS(MAX_OS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .buf_free_i   (buf_free),
    .busy_o       (busy),
    .tile_done_o  (tile_done),
    .map_done_o   (map_done),
    .araddr_o     (araddr),
    .arlen_o      (arlen),
    .arburst_o    (arburst),
    .arvalid_o    (arvalid),
    .arready_i    (arready),
    .rlast_hs_i   (rlast_hs),
`ifdef IFM_LOAD_PERF_EN
    .stall_cnt_o  (stall_cnt),
    .bufwait_cnt_o(bufwait_cnt),
`endif
    .err_o        (err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Address of the k-th burst of the map, from its tile/row/column position.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
    int tile, w, tx, ty, r, b;
    logic [31:0] off;
    tile = k / TB;
    w    = k % TB;
    tx   = tile % TX;
    ty   = tile / TX;
    r    = w / RB;
    b    = w % RB;
    off  = 32'(((ty * TILE_H + r) * IW + tx * TILE_W + b * BURST_LEN) * BPW);
    return base + off;
  endfunction

  // Model state, owned by the compare process.
  logic        mdl_en;
  int          m_hs, m_rl, m_td, pend, wait_cnt;
  logic [31:0] m_base, prev_addr;
  logic        m_busy, m_md_pend, m_done, prev_av, prev_ar, prev_bf, hs, acc;

  always @(negedge clk) begin
    if (!rst_n || !mdl_en) begin
      pend = 0; m_busy = 0; m_md_pend = 0; prev_av = 0; prev_ar = 0; wait_cnt = 0;
    end else begin
      hs  = arvalid && arready;
      acc = start && !m_busy;
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
      chk("map_done", {63'd0, map_done}, {63'd0, m_md_pend});
      chk("err", {63'd0, err}, 64'd0);
      if (m_md_pend) begin
        m_busy = 0; m_md_pend = 0; m_done = 1;
      end
      if (acc) begin
        m_hs = 0; m_rl = 0; m_td = 0; m_base = base_addr; m_busy = 1; m_done = 0;
      end
      if (arvalid) chk("os_cap", {63'd0, (m_hs - m_rl) < int'(MAX_OS)}, 64'd1);
      if (prev_av && !prev_ar) begin
        chk("av_hold", {63'd0, arvalid}, 64'd1);
        chk("addr_hold", {32'd0, araddr}, {32'd0, prev_addr});
      end
      if (arvalid && !prev_av && (m_hs % TB == 0)) chk("buf_gate", {63'd0, prev_bf}, 64'd1);
      if (tile_done) begin
        chk("td_rl", 64'(m_rl), 64'((m_td + 1) * TB));
        chk("td_hs", 64'(m_hs), 64'((m_td + 1) * TB));
        m_td++;
        if (m_td == NT) m_md_pend = 1;
        wait_cnt = 0;
      end else if (m_hs == m_rl && m_hs == (m_td + 1) * TB) begin
        wait_cnt++;
        if (wait_cnt > 2) begin
          n_cmp++; n_fail++;
          $display("FAIL td_late: tile %0d complete but no tile_done", m_td);
          wait_cnt = 0;
        end
      end
      if (hs) begin
        chk("araddr", {32'd0, araddr}, {32'd0, exp_addr(m_base, m_hs)});
        if (m_base == 32'h1000_0000) begin
          case (m_hs)
            0:  chk("pin_b0", {32'd0, araddr}, 64'h1000_0000);
            2:  chk("pin_b2", {32'd0, araddr}, 64'h1000_0380);
            14: chk("pin_t1", {32'd0, araddr}, 64'h1000_0080);
            98: chk("pin_t7", {32'd0, araddr}, 64'h1000_1880);
            default: ;
          endcase
        end
        m_hs++;
      end
      if (rlast_hs) m_rl++;
      pend = pend + (hs ? 1 : 0) - (rlast_hs ? 1 : 0);
      prev_av = arvalid; prev_ar = arready; prev_addr = araddr; prev_bf = buf_free;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_tile_done"}, {63'd0, tile_done}, 64'd0);
    chk({tag, "_map_done"}, {63'd0, map_done}, 64'd0);
    chk({tag, "_arvalid"}, {63'd0, arvalid}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_araddr"}, {32'd0, araddr}, 64'd0);
  endtask

  logic [31:0] first4 [4];
  int cyc_n;

  initial begin
    first4 = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0380, 32'h1000_03C0};
    rst_n = 0; start = 0; base_addr = '0; buf_free = 0; arready = 0; rlast_hs = 0;
    mdl_en = 0; m_done = 0; m_hs = 0; m_rl = 0; m_td = 0; m_base = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk_reset("rst");
    chk("arlen", {56'd0, arlen}, 64'd15);
    chk("arburst", {62'd0, arburst}, 64'd1);

    // Spurious rlast while idle sets the sticky error.
    @(posedge clk); #1 rlast_hs = 1;
    @(posedge clk); #1 rlast_hs = 0;
    @(negedge clk);
    chk("err_spur", {63'd0, err}, 64'd1);
    chk("busy_spur", {63'd0, busy}, 64'd0);

    @(posedge clk); #1 start = 1; base_addr = 32'h1000_0000; buf_free = 1; arready = 1;
    @(negedge clk);
    chk("c0_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1 start = 0; base_addr = 32'hdead_beef;
    @(negedge clk);
    chk("c1_busy", {63'd0, busy}, 64'd1);
    chk("c1_arvalid", {63'd0, arvalid}, 64'd0);
    chk("c1_err_clr", {63'd0, err}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("first_av", {63'd0, arvalid}, 64'd1);
      chk("first_addr", {32'd0, araddr}, {32'd0, first4[i]});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("cap_av", {63'd0, arvalid}, 64'd0);
    end

    // One rlast frees one slot; arready held low keeps the request stable.
    @(posedge clk); #1 arready = 0; rlast_hs = 1;
    @(negedge clk);
    @(posedge clk); #1 rlast_hs = 0;
    @(negedge clk);
    chk("no_credit", {63'd0, arvalid}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_av", {63'd0, arvalid}, 64'd1);
      chk("hold_addr", {32'd0, araddr}, 64'h1000_0700);
    end
    @(posedge clk); #1 arready = 1;
    @(negedge clk);
    chk("re_av", {63'd0, arvalid}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 arready = 0;
      @(negedge clk);
      chk("one_more", {63'd0, arvalid}, 64'd0);
    end

    // AR handshake and rlast in the same cycle leave the outstanding count unchanged.
    @(posedge clk); #1 rlast_hs = 1;
    @(negedge clk);
    @(posedge clk); #1 rlast_hs = 0;
    @(negedge clk);
    chk("no_credit2", {63'd0, arvalid}, 64'd0);
    @(posedge clk); #1 arready = 1; rlast_hs = 1;
    @(negedge clk);
    chk("both_av", {63'd0, arvalid}, 64'd1);
    chk("both_addr", {32'd0, araddr}, 64'h1000_0740);
    @(posedge clk); #1 arready = 0; rlast_hs = 0;
    @(negedge clk);
    chk("both_gap", {63'd0, arvalid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("both_os", {63'd0, arvalid}, 64'd1);
    chk("both_next", {32'd0, araddr}, 64'h1000_0A80);

    // Reset in the middle of issuing.
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk_reset("midrst");

    // Randomized full map from the same base, with ignored restarts while busy.
    @(posedge clk); #1 start = 1; base_addr = 32'h1000_0000; mdl_en = 1; buf_free = 1;
    @(posedge clk); #1 start = 0;
    cyc_n = 0;
    while (!m_done && cyc_n < 40000) begin
      start     = busy && ($urandom_range(0, 99) == 0);
      base_addr = $urandom;
      arready   = ($urandom_range(0, 3) != 0);
      rlast_hs  = (pend > 0) && ($urandom_range(0, 2) != 0);
      buf_free  = ($urandom_range(0, 5) != 0);
      @(posedge clk); #1;
      cyc_n++;
    end
    if (!m_done) begin
      n_cmp++; n_fail++;
      $display("FAIL map_timeout: %0d tiles done after %0d cycles", m_td, cyc_n);
    end
    start = 0; arready = 0; rlast_hs = 0;
    repeat (3) @(posedge clk);
    #1 mdl_en = 0;
    chk("tiles", 64'(m_td), 64'(NT));
    chk("bursts", 64'(m_hs), 64'(NT * TB));
    @(negedge clk);
    chk("end_busy", {63'd0, busy}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
